// File: rtl/s38584_rdbk_sequencer.sv
// rtl/s38584_rdbk_sequencer.sv - readback sequencer for the s38584 n1005 partial-output cone
//
// Purpose: walks a range of 8-bit cone select codes, holds each code for a settle
// window with the cone enable high, samples the 1-bit cone result and packs the
// samples LSB-first into WORD_W-bit words that leave on a valid/ready stream.
//
// Ports:
//   CK, RST              clock (rising edge), synchronous active-high reset
//   start, base_addr,    scan request: first code and number of codes
//   count                (0..256, larger values clamp to 256); start only seen in IDLE
//   abort                drop the scan in progress, return to IDLE without done
//   busy, done           not-IDLE flag, one-cycle completion pulse
//   cone_addr, cone_en   select code and enable (g35) driven into the cone
//   cone_bit             cone result (n1005)
//   word_data, word_valid, word_ready, word_last   packed-sample output stream
module s38584_rdbk_sequencer #(
  parameter int WORD_W     = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        base_addr,
  input  logic [8:0]        count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cone_addr,
  output logic              cone_en,
  input  logic              cone_bit,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last
);

  localparam int POS_W = $clog2(WORD_W + 1);
  // Last SETTLE count value before moving to SAMPLE; unused when SETTLE_CYC is 0.
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_EMIT, S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_base;
  logic [8:0]        r_count;
  logic [8:0]        r_idx;
  logic [POS_W-1:0]  r_pos;
  logic [3:0]        r_settle;
  logic [7:0]        r_addr;
  logic [WORD_W-1:0] r_word;

  logic w_load;
  logic w_sample;
  logic w_accept;
  logic w_clear;
  logic w_word_full;
  logic w_scan_end;
  logic w_is_last;

  assign w_word_full = (r_pos == POS_W'(WORD_W - 1));
  assign w_scan_end  = ((r_idx + 9'd1) == r_count);
  assign w_is_last   = (r_idx == r_count);

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_sample = 1'b0;
    w_accept = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (count == 9'd0) begin
            w_next = S_FIN;
          end else begin
            w_next = S_DRIVE;
            w_load = 1'b1;
          end
        end
      end
      S_DRIVE:  w_next = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
      S_SETTLE: if (r_settle == SETTLE_LAST) w_next = S_SAMPLE;
      S_SAMPLE: begin
        w_sample = 1'b1;
        w_next   = (w_word_full || w_scan_end) ? S_EMIT : S_DRIVE;
      end
      S_EMIT: begin
        if (word_ready) begin
          w_accept = 1'b1;
          w_next   = w_is_last ? S_FIN : S_DRIVE;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a coincident handshake.
    if (abort && (r_state != S_IDLE)) begin
      w_next   = S_IDLE;
      w_sample = 1'b0;
      w_accept = 1'b0;
      w_clear  = 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_base   <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_pos    <= '0;
      r_settle <= '0;
      r_addr   <= '0;
      r_word   <= '0;
    end else begin
      if (w_load) begin
        r_base  <= base_addr;
        r_count <= (count > 9'd256) ? 9'd256 : count;
        r_idx   <= '0;
        r_pos   <= '0;
        r_word  <= '0;
        r_addr  <= base_addr;
      end
      if (r_state == S_DRIVE)       r_settle <= '0;
      else if (r_state == S_SETTLE) r_settle <= r_settle + 4'd1;
      if (w_sample) begin
        r_word <= r_word | ({{(WORD_W-1){1'b0}}, cone_bit} << r_pos);
        r_pos  <= r_pos + POS_W'(1);
        r_idx  <= r_idx + 9'd1;
        // The select only moves on entry to DRIVE so it never changes while waiting in EMIT.
        if (w_next == S_DRIVE) r_addr <= r_base + r_idx[7:0] + 8'd1;
      end
      if (w_accept) begin
        r_word <= '0;
        r_pos  <= '0;
        if (w_next == S_DRIVE) r_addr <= r_base + r_idx[7:0];
      end
      if (w_clear) begin
        r_word <= '0;
        r_pos  <= '0;
        r_idx  <= '0;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);
  assign cone_en    = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign cone_addr  = r_addr;
  assign word_data  = r_word;
  assign word_valid = (r_state == S_EMIT);
  assign word_last  = (r_state == S_EMIT) && w_is_last;

endmodule

// File: tb/tb_s38584_rdbk_sequencer.sv
// tb/tb_s38584_rdbk_sequencer.sv - self-checking bench for s38584_rdbk_sequencer
module tb_s38584_rdbk_sequencer;
  localparam int WORD_W     = 16;
  localparam int SETTLE_CYC = 1;

  logic              CK = 1'b0;
  logic              RST, start, abort, word_ready;
  logic [7:0]        base_addr;
  logic [8:0]        count;
  logic              busy, done, cone_en, word_valid, word_last, cone_bit;
  logic [7:0]        cone_addr;
  logic [WORD_W-1:0] word_data;

  int ntests = 0;
  int nfail  = 0;
  bit mode   = 1'b0;
  bit tbl [256];

  s38584_rdbk_sequencer #(.WORD_W(WORD_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .CK(CK), .RST(RST), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .cone_addr(cone_addr),
    .cone_en(cone_en), .cone_bit(cone_bit), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last)
  );

  always #5 CK = ~CK;

  // Cone stand-in: forced to 0 when disabled.
  assign cone_bit = cone_en & (mode ? tbl[cone_addr] : cone_addr[0]);

  function automatic bit ref_bit(input logic [7:0] a);
    return mode ? tbl[a] : a[0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  32'(busy), 0);
    chk({nm, "_done"},  32'(done), 0);
    chk({nm, "_en"},    32'(cone_en), 0);
    chk({nm, "_valid"}, 32'(word_valid), 0);
    chk({nm, "_last"},  32'(word_last), 0);
  endtask

  task automatic run_scan(input logic [7:0] b, input logic [8:0] c, input int gap,
                          input int inj, output int nwords, output logic [31:0] first);
    logic [WORD_W-1:0] exp_w[$], got_w[$];
    bit                exp_l[$], got_l[$];
    logic [7:0]        exp_a[$], got_a[$];
    logic [WORD_W-1:0] acc, held;
    logic [7:0]        a, prev_a;
    bit                prev_en;
    int n, p, cyc, waitc, hs_cyc, done_cyc, first_valid, bad, k;
    // Reference: n = min(count,256) codes, LSB-first packing, zero-filled tail.
    n = (c > 9'd256) ? 256 : int'(c);
    acc = '0; p = 0;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_a.push_back(a);
      acc[p] = ref_bit(a);
      p++;
      if (p == WORD_W || i == n - 1) begin
        exp_w.push_back(acc);
        exp_l.push_back(i == n - 1);
        acc = '0; p = 0;
      end
    end
    base_addr = b; count = c; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; waitc = 0; hs_cyc = -1; done_cyc = -1; first_valid = -1;
    prev_en = 1'b0; prev_a = '0; held = '0;
    while (cyc < 6000 && done_cyc < 0) begin
      if (cyc == inj) begin
        start = 1'b1; base_addr = b ^ 8'h80; count = 9'd3;
      end else if (cyc == inj + 1) begin
        start = 1'b0; base_addr = b; count = c;
      end
      if (cyc == 0) chk("busy_after_start", 32'(busy), 1);
      if (done) done_cyc = cyc;
      if (cone_en && (!prev_en || cone_addr != prev_a)) got_a.push_back(cone_addr);
      prev_en = cone_en; prev_a = cone_addr;
      if (word_ready) begin
        word_ready = 1'b0;
      end else if (word_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (waitc == 0) held = word_data;
        else chk("data_held", 32'(word_data), 32'(held));
        if (waitc >= gap) begin
          got_w.push_back(word_data);
          got_l.push_back(word_last);
          word_ready = 1'b1;
          hs_cyc = cyc;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      step();
      cyc++;
    end
    word_ready = 1'b0;
    chk("done_seen", 32'(done_cyc >= 0), 1);
    chk("idle_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("num_words", 32'(got_w.size()), 32'(exp_w.size()));
    if (n == 0) begin
      chk("empty_done_latency", 32'(done_cyc), 0);
    end else begin
      k = (n < WORD_W) ? n : WORD_W;
      chk("start_to_emit", 32'(first_valid), 32'(k * (2 + SETTLE_CYC)));
      chk("done_after_hs", 32'(done_cyc), 32'(hs_cyc + 1));
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      chk($sformatf("word%0d_data", i), 32'(got_w[i]), 32'(exp_w[i]));
      chk($sformatf("word%0d_last", i), 32'(got_l[i]), 32'(exp_l[i]));
    end
    bad = 0;
    for (int i = 0; i < exp_a.size(); i++)
      if (i >= got_a.size() || got_a[i] !== exp_a[i]) bad++;
    chk("addr_seq_len", 32'(got_a.size()), 32'(exp_a.size()));
    chk("addr_seq_errs", 32'(bad), 0);
    nwords = got_w.size();
    first  = (got_w.size() > 0) ? 32'(got_w[0]) : 32'd0;
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  cnt;
    int          gap;
    int          inj;
    int          exp_words;
    logic [31:0] exp_first;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    int          nw, to;
    logic [31:0] fw;

    vecs[0] = '{8'h00, 9'd16,  0,  -1, 1,  32'hAAAA};
    vecs[1] = '{8'hFE, 9'd4,   0,  -1, 1,  32'h000A};
    vecs[2] = '{8'h00, 9'd40,  10, -1, 3,  32'hAAAA};
    vecs[3] = '{8'h00, 9'd0,   0,  -1, 0,  32'h0000};
    vecs[4] = '{8'h00, 9'd300, 1,  -1, 16, 32'hAAAA};
    vecs[5] = '{8'h31, 9'd17,  2,  3,  2,  32'h5555};

    RST = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b0;
    base_addr = '0; count = '0;
    step(); step();
    chk_zero("reset");
    chk("reset_addr", 32'(cone_addr), 0);
    chk("reset_data", 32'(word_data), 0);
    RST = 1'b0;
    step();

    mode = 1'b0;
    for (int v = 0; v < 6; v++) begin
      run_scan(vecs[v].base, vecs[v].cnt, vecs[v].gap, vecs[v].inj, nw, fw);
      chk($sformatf("vec%0d_words", v), 32'(nw), 32'(vecs[v].exp_words));
      chk($sformatf("vec%0d_first", v), fw, vecs[v].exp_first);
      step();
    end

    // Abort while settling.
    base_addr = 8'h00; count = 9'd16; start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_zero("abort_settle");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_settle_nodone", 32'(done | busy), 0);
    end

    // Abort in EMIT with ready high.
    base_addr = 8'h10; count = 9'd4; start = 1'b1;
    step();
    start = 1'b0;
    to = 0;
    while (!word_valid && to < 100) begin step(); to++; end
    chk("abort_emit_reached", 32'(word_valid), 1);
    abort = 1'b1; word_ready = 1'b1;
    step();
    abort = 1'b0; word_ready = 1'b0;
    chk_zero("abort_emit");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_emit_quiet", 32'(done | busy | word_valid), 0);
    end

    // Abort alone in IDLE has no effect; start with abort in IDLE is accepted.
    abort = 1'b1;
    step();
    chk("abort_idle_noop", 32'(busy), 0);
    abort = 1'b1; start = 1'b1; base_addr = 8'h40; count = 9'd2;
    step();
    abort = 1'b0; start = 1'b0;
    chk("start_with_abort", 32'(busy), 1);
    to = 0;
    while (!done && to < 100) begin
      if (word_valid) begin
        chk("swa_data", 32'(word_data), 32'h0002);
        chk("swa_last", 32'(word_last), 1);
        word_ready = 1'b1;
      end
      step(); to++;
    end
    word_ready = 1'b0;
    chk("swa_done", 32'(done), 1);
    step();

    // Reset in the middle of a scan.
    base_addr = 8'h05; count = 9'd40; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_zero("midrst");
    chk("midrst_addr", 32'(cone_addr), 0);
    chk("midrst_data", 32'(word_data), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_quiet", 32'(done | busy | word_valid), 0);
    end

    // Randomized scans against the reference model with a random cone.
    mode = 1'b1;
    for (int i = 0; i < 256; i++) tbl[i] = 1'($urandom);
    for (int r = 0; r < 6; r++) begin
      run_scan(8'($urandom), 9'($urandom_range(1, 70)), int'($urandom_range(0, 3)),
               (r == 2) ? 5 : -1, nw, fw);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
